multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

Multicycle MIPS datapath: the successor to the single-cycle datapath. It runs each instruction through a fetch/decode/execute/memory/writeback state machine and stalls on cache handshakes. It instantiates the existing `register_file` and `alu`. It sits between `datapath_cache_if` and the caches and adds three behaviours: a retire pulse, a sticky halt, and an optional data-memory timeout fault.

## Interface
Parameters:
- `PC_INIT`, 0: PC reset value. Must be word-aligned.
- `HALT_ON_OVERFLOW`, 1: when 1, signed overflow on ADD/ADDI/SUB halts the core without writeback. When 0, the result is written normally.
- `DMEM_MAX_WAIT`, 0: maximum cycles spent in MEM waiting for `dhit`. 0 means unbounded.

Ports:
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `ihit`  in  1  instruction read complete; `imemload` is valid this cycle.
- `imemload`  in  32  fetched instruction.
- `imemREN`  out  1  instruction read request.
- `imemaddr`  out  32  instruction address.
- `dhit`  in  1  data access complete.
- `dmemload`  in  32  load data.
- `dmemREN`  out  1  data read request.
- `dmemWEN`  out  1  data write request.
- `dmemaddr`  out  32  data address.
- `dmemstore`  out  32  store data.
- `halt`  out  1  sticky; core stopped.
- `fault`  out  1  sticky; data-memory timeout occurred.
- `retired`  out  1  one-cycle pulse when an instruction completes.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALTED.
- Internal registers: `pc`, `ir`, `A`, `B`, `aluout`, `mdr`, wait counter.
- FETCH:
  - Drive `imemREN`=1 and `imemaddr`=`pc`.
  - On `ihit`: latch `ir`<=`imemload`, set `pc`<=`pc`+4, go to DECODE.
- DECODE: latch `A`=rdat1[rs] and `B`=rdat2[rt], go to EXEC.
- EXEC, ALU operations:
  - R-type ALU ops and ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU/LUI: `aluout`<=result, go to WB.
  - Immediate extension:
    - Sign-extend for ADDI, ADDIU, SLTI, SLTIU, LW, SW.
    - `{imm,16'b0}` for LUI.
    - Zero-extend otherwise.
  - SLL/SRL: portb = shamt.
- EXEC, memory operations:
  - LW/SW: `aluout`<=A+sext(imm), go to MEM.
- EXEC, control transfer (no WB):
  - BEQ/BNE: if taken, `pc`<=`pc`+(sext(imm)<<2), then FETCH. `pc` here is already +4.
  - J: `pc`<={`pc`[31:28],addr,2'b00}, then FETCH.
  - JR: `pc`<=A, then FETCH.
  - JAL: `aluout`<=`pc` (the +4 value), jump target as for J, go to WB.
- EXEC, special cases:
  - HALT opcode: go to HALTED.
  - Overflow on ADD/ADDI/SUB with `HALT_ON_OVERFLOW`=1: go to HALTED, no regfile write, `retired`=0.
  - Unknown opcode: treated as NOP, go to FETCH with `retired`=1.
- MEM:
  - Drive `dmemaddr`=`aluout`.
  - LW: `dmemREN`=1. SW: `dmemWEN`=1, `dmemstore`=B.
  - On `dhit`: LW latches `mdr` and goes to WB. SW goes to FETCH with `retired`=1.
  - Timeout: if `DMEM_MAX_WAIT`>0 and the wait counter reaches `DMEM_MAX_WAIT` without `dhit`, set `fault`=1 and `halt`=1 and go to HALTED.
- WB:
  - `WEN`=1 for exactly one cycle.
  - wsel: rd for R-type, 31 for JAL, rt otherwise.
  - wdat: `mdr` for LW, `aluout` otherwise.
  - `retired`=1 this cycle, then FETCH.
  - Writes to r0 are discarded by `register_file`.
- HALTED: all memory requests 0, `halt`=1. Exit only via reset.

## Timing
- Reset (async, while `nRST`=0):
  - `pc`=`PC_INIT`, state FETCH, `ir`/`A`/`B`/`aluout`/`mdr`/counter = 0.
  - Outputs: `halt`/`fault`/`retired`/`imemREN`/`dmemREN`/`dmemWEN` = 0, `imemaddr`=`PC_INIT`, `dmemaddr`=0, `dmemstore`=0.
  - After release: `imemREN`=1 on the first cycle.
- Minimum latency with `ihit`/`dhit` on the first request cycle:
  - ALU op: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - JAL: 4 cycles.
  - Branch/J/JR: 3 cycles.
- Each stall cycle without `ihit`/`dhit` adds one cycle.
- Request signals are held constant (address and data) until the hit cycle and deasserted the cycle after.
- `ihit` and `dhit` outside FETCH/MEM are ignored.
- `retired` is asserted only in the final state cycle of a non-halting instruction.
- Wait counter:
  - Resets on MEM entry and counts MEM cycles.
  - `dhit` in the same cycle the counter reaches the limit wins: no fault.
- `pc`+4 wraps modulo 2^32. Branch target arithmetic is modulo 2^32.
- Reset asserted mid-MEM drops `dmemREN`/`dmemWEN` asynchronously; no regfile write occurs.

## Test plan
- Reset: `PC_INIT`=0x100, then `imemload`=0x24010005 (ADDIU r1,r0,5) with immediate `ihit`.
  - `imemaddr`=0x100 first.
  - r1=5 written in cycle 4, `retired` pulses once.
  - Next fetch address is 0x104.
- LW r2,4(r1) with r1=0x200, `dhit` delayed 3 cycles, `dmemload`=0xDEADBEEF.
  - `dmemaddr`=0x204 held for 4 cycles.
  - r2=0xDEADBEEF.
  - Total 8 cycles.
- BEQ r0,r0,-1 at 0x40: next `imemaddr`=0x40. BNE r0,r0 at 0x40: next `imemaddr`=0x44.
- JAL 0x0000010 at 0x3C: r31=0x40, next `imemaddr`=0x40.
- Overflow and HALT:
  - r1=0x7FFFFFFF, ADDI r1,r1,1: `halt`=1, r1 unchanged, no `retired`.
  - With `HALT_ON_OVERFLOW`=0: r1=0x80000000.
  - HALT opcode: `halt` stays 1 with `ihit` toggling.
- Timeout and reset:
  - `DMEM_MAX_WAIT`=4, SW with no `dhit`: `fault`=`halt`=1 after 4 MEM cycles, `dmemWEN` low afterwards.
  - Repeat with `nRST` pulsed during MEM: outputs return to reset values immediately and fetch restarts at `PC_INIT`.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS datapath: FETCH/DECODE/EXEC/MEM/WB sequencing around a register file and ALU,
// with a retire pulse, a sticky halt and an optional data-memory timeout fault.
package multicycle_datapath_pkg;
    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRL  = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
endpackage

module register_file (
    input  logic        CLK,
    input  logic        WEN,
    input  logic [4:0]  wsel,
    input  logic [31:0] wdat,
    input  logic [4:0]  rsel1,
    input  logic [4:0]  rsel2,
    output logic [31:0] rdat1,
    output logic [31:0] rdat2
);
    logic [31:0] regs [32];

    always_ff @(posedge CLK) begin
        if (WEN && wsel != 5'd0) regs[wsel] <= wdat;
    end

    assign rdat1 = (rsel1 == 5'd0) ? 32'd0 : regs[rsel1];
    assign rdat2 = (rsel2 == 5'd0) ? 32'd0 : regs[rsel2];
endmodule

module alu
    import multicycle_datapath_pkg::*;
(
    input  logic [31:0] porta,
    input  logic [31:0] portb,
    input  logic [3:0]  aluop,
    output logic [31:0] outport,
    output logic        overflow
);
    always_comb begin
        outport  = 32'd0;
        overflow = 1'b0;
        case (aluop)
            ALU_SLL:  outport = porta << portb[4:0];
            ALU_SRL:  outport = porta >> portb[4:0];
            ALU_ADD: begin
                outport  = porta + portb;
                overflow = (porta[31] == portb[31]) && (outport[31] != porta[31]);
            end
            ALU_SUB: begin
                outport  = porta - portb;
                overflow = (porta[31] != portb[31]) && (outport[31] != porta[31]);
            end
            ALU_AND:  outport = porta & portb;
            ALU_OR:   outport = porta | portb;
            ALU_XOR:  outport = porta ^ portb;
            ALU_NOR:  outport = ~(porta | portb);
            ALU_SLT:  outport = {31'd0, $signed(porta) < $signed(portb)};
            ALU_SLTU: outport = {31'd0, porta < portb};
            default:  outport = 32'd0;
        endcase
    end
endmodule

module multicycle_datapath
    import multicycle_datapath_pkg::*;
#(
    parameter logic [31:0] PC_INIT          = 32'h0,
    parameter bit          HALT_ON_OVERFLOW = 1'b1,
    parameter int unsigned DMEM_MAX_WAIT    = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        halt,
    output logic        fault,
    output logic        retired
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08, F_ADD = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    logic [2:0]  state;
    logic [31:0] pc, ir, a_reg, b_reg, aluout, mdr, wait_cnt;
    logic        fault_q;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] sext_imm, zext_imm, jump_target, branch_target;
    logic [31:0] rdat1, rdat2, alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        alu_ovf, alu_wb, ovf_chk, is_mem, is_jr, exec_retire, timeout, br_taken;

    assign op            = ir[31:26];
    assign rs            = ir[25:21];
    assign rt            = ir[20:16];
    assign rd            = ir[15:11];
    assign shamt         = ir[10:6];
    assign funct         = ir[5:0];
    assign sext_imm      = {{16{ir[15]}}, ir[15:0]};
    assign zext_imm      = {16'd0, ir[15:0]};
    assign jump_target   = {pc[31:28], ir[25:0], 2'b00};
    assign branch_target = pc + (sext_imm << 2);
    assign is_mem        = (op == OP_LW) || (op == OP_SW);
    assign is_jr         = (op == OP_RTYPE) && (funct == F_JR);
    assign br_taken      = ((op == OP_BEQ) && (a_reg == b_reg)) || ((op == OP_BNE) && (a_reg != b_reg));
    assign exec_retire   = (op != OP_HALT) && !alu_wb && !is_mem && (op != OP_JAL);
    assign timeout       = (DMEM_MAX_WAIT != 0) && (wait_cnt == DMEM_MAX_WAIT - 1);

    // Operand selection: shifts take rt with shamt, LUI forces a zero base.
    always_comb begin
        alu_op  = ALU_ADD;
        alu_a   = a_reg;
        alu_b   = b_reg;
        alu_wb  = 1'b0;
        ovf_chk = 1'b0;
        case (op)
            OP_RTYPE: begin
                alu_wb = 1'b1;
                case (funct)
                    F_SLL:   begin alu_op = ALU_SLL; alu_a = b_reg; alu_b = {27'd0, shamt}; end
                    F_SRL:   begin alu_op = ALU_SRL; alu_a = b_reg; alu_b = {27'd0, shamt}; end
                    F_ADD:   ovf_chk = 1'b1;
                    F_ADDU:  alu_op = ALU_ADD;
                    F_SUB:   begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
                    F_SUBU:  alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_XOR:   alu_op = ALU_XOR;
                    F_NOR:   alu_op = ALU_NOR;
                    F_SLT:   alu_op = ALU_SLT;
                    F_SLTU:  alu_op = ALU_SLTU;
                    default: alu_wb = 1'b0;
                endcase
            end
            OP_ADDI:  begin alu_b = sext_imm; alu_wb = 1'b1; ovf_chk = 1'b1; end
            OP_ADDIU: begin alu_b = sext_imm; alu_wb = 1'b1; end
            OP_SLTI:  begin alu_op = ALU_SLT;  alu_b = sext_imm; alu_wb = 1'b1; end
            OP_SLTIU: begin alu_op = ALU_SLTU; alu_b = sext_imm; alu_wb = 1'b1; end
            OP_ANDI:  begin alu_op = ALU_AND;  alu_b = zext_imm; alu_wb = 1'b1; end
            OP_ORI:   begin alu_op = ALU_OR;   alu_b = zext_imm; alu_wb = 1'b1; end
            OP_XORI:  begin alu_op = ALU_XOR;  alu_b = zext_imm; alu_wb = 1'b1; end
            OP_LUI:   begin alu_a = 32'd0; alu_b = {ir[15:0], 16'd0}; alu_wb = 1'b1; end
            OP_LW, OP_SW: alu_b = sext_imm;
            default: ;
        endcase
    end

    register_file u_rf (
        .CLK(CLK), .WEN(state == S_WB),
        .wsel((op == OP_JAL) ? 5'd31 : (op == OP_RTYPE) ? rd : rt),
        .wdat((op == OP_LW) ? mdr : aluout),
        .rsel1(rs), .rsel2(rt), .rdat1(rdat1), .rdat2(rdat2)
    );

    alu u_alu (.porta(alu_a), .portb(alu_b), .aluop(alu_op), .outport(alu_out), .overflow(alu_ovf));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= S_FETCH;
            pc       <= PC_INIT;
            ir       <= 32'd0;
            a_reg    <= 32'd0;
            b_reg    <= 32'd0;
            aluout   <= 32'd0;
            mdr      <= 32'd0;
            wait_cnt <= 32'd0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (ihit) begin
                    ir    <= imemload;
                    pc    <= pc + 32'd4;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a_reg <= rdat1;
                    b_reg <= rdat2;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    wait_cnt <= 32'd0;
                    if (op == OP_HALT) begin
                        state <= S_HALTED;
                    end else if (alu_wb) begin
                        if (HALT_ON_OVERFLOW && ovf_chk && alu_ovf) begin
                            state <= S_HALTED;
                        end else begin
                            aluout <= alu_out;
                            state  <= S_WB;
                        end
                    end else if (is_mem) begin
                        aluout <= alu_out;
                        state  <= S_MEM;
                    end else if (op == OP_JAL) begin
                        aluout <= pc;
                        pc     <= jump_target;
                        state  <= S_WB;
                    end else begin
                        if (br_taken)       pc <= branch_target;
                        else if (op == OP_J) pc <= jump_target;
                        else if (is_jr)      pc <= a_reg;
                        state <= S_FETCH;
                    end
                end
                // A hit on the limiting cycle still completes the access.
                S_MEM: begin
                    if (dhit) begin
                        if (op == OP_LW) begin
                            mdr   <= dmemload;
                            state <= S_WB;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else if (timeout) begin
                        fault_q <= 1'b1;
                        state   <= S_HALTED;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_WB:     state <= S_FETCH;
                S_HALTED: state <= S_HALTED;
                default:  state <= S_FETCH;
            endcase
        end
    end

    assign imemREN   = nRST && (state == S_FETCH);
    assign imemaddr  = pc;
    assign dmemREN   = (state == S_MEM) && (op == OP_LW);
    assign dmemWEN   = (state == S_MEM) && (op == OP_SW);
    assign dmemaddr  = (state == S_MEM) ? aluout : 32'd0;
    assign dmemstore = dmemWEN ? b_reg : 32'd0;
    assign halt      = (state == S_HALTED);
    assign fault     = fault_q;
    assign retired   = (state == S_WB) || (dmemWEN && dhit) || ((state == S_EXEC) && exec_retire);
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: two instances (overflow halts / overflow writes)
// share one instruction and data stream; expected values are hand-computed MIPS results.
module tb_multicycle_datapath;
    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        ihit = 1'b0, dhit = 1'b0;
    logic [31:0] imemload = 32'd0, dmemload = 32'd0;
    logic        imemREN_a, dmemREN_a, dmemWEN_a, halt_a, fault_a, retired_a;
    logic [31:0] imemaddr_a, dmemaddr_a, dmemstore_a;
    logic        imemREN_b, dmemREN_b, dmemWEN_b, halt_b, fault_b, retired_b;
    logic [31:0] imemaddr_b, dmemaddr_b, dmemstore_b;
    int total = 0, bad = 0, ret_a = 0, ret_b = 0;

    multicycle_datapath #(.PC_INIT(32'h100), .HALT_ON_OVERFLOW(1'b1), .DMEM_MAX_WAIT(4)) dut_a (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN_a),
        .imemaddr(imemaddr_a), .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN_a),
        .dmemWEN(dmemWEN_a), .dmemaddr(dmemaddr_a), .dmemstore(dmemstore_a),
        .halt(halt_a), .fault(fault_a), .retired(retired_a));

    multicycle_datapath #(.PC_INIT(32'h100), .HALT_ON_OVERFLOW(1'b0), .DMEM_MAX_WAIT(0)) dut_b (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN_b),
        .imemaddr(imemaddr_b), .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN_b),
        .dmemWEN(dmemWEN_b), .dmemaddr(dmemaddr_b), .dmemstore(dmemstore_b),
        .halt(halt_b), .fault(fault_b), .retired(retired_b));

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (retired_a) ret_a = ret_a + 1;
        if (retired_b) ret_b = ret_b + 1;
    end

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; imemload = 32'd0; dmemload = 32'd0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Runs one instruction on the shared stream; returns cycle count and first MEM-cycle request.
    task automatic exec_instr(input logic [31:0] instr, input int idelay, input int ddelay,
                              input logic [31:0] ldata, output int cycles, output int mem_cycles,
                              output logic [31:0] maddr, output logic [31:0] mstore, output logic held);
        int dwait;
        dwait = 0; cycles = 0; mem_cycles = 0; maddr = 32'd0; mstore = 32'd0; held = 1'b1;
        for (int k = 0; k < idelay; k++) begin
            step();
            cycles++;
        end
        imemload = instr; ihit = 1'b1;
        step();
        cycles++;
        ihit = 1'b0; imemload = 32'd0;
        while (!imemREN_a && !halt_a && cycles < 40) begin
            dhit = 1'b0;
            if (dmemREN_a || dmemWEN_a) begin
                if (mem_cycles == 0) begin
                    maddr = dmemaddr_a; mstore = dmemstore_a;
                end else if (dmemaddr_a != maddr || dmemstore_a != mstore) begin
                    held = 1'b0;
                end
                mem_cycles++;
                if (dwait == ddelay) begin dhit = 1'b1; dmemload = ldata; end
                dwait++;
            end
            step();
            cycles++;
        end
        dhit = 1'b0;
    endtask

    task automatic test_reset();
        int c, mc, r0;
        logic [31:0] ma, ms;
        logic hd;
        nRST = 1'b0;
        #1;
        total++; if (imemREN_a !== 1'b0) begin bad++; $display("FAIL rst_imemREN got=%b want=0", imemREN_a); end
        total++; if (imemaddr_a !== 32'h100) begin bad++; $display("FAIL rst_imemaddr got=%h want=00000100", imemaddr_a); end
        total++; if ({dmemREN_a, dmemWEN_a, halt_a, fault_a, retired_a} !== 5'b0) begin bad++; $display("FAIL rst_ctrl got=%b want=00000", {dmemREN_a, dmemWEN_a, halt_a, fault_a, retired_a}); end
        total++; if ({dmemaddr_a, dmemstore_a} !== 64'd0) begin bad++; $display("FAIL rst_dmem got=%h want=0", {dmemaddr_a, dmemstore_a}); end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        total++; if (imemREN_a !== 1'b1) begin bad++; $display("FAIL rel_imemREN got=%b want=1", imemREN_a); end
        r0 = ret_a;
        exec_instr(32'h24010005, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (c != 4) begin bad++; $display("FAIL addiu_latency got=%0d want=4", c); end
        total++; if (dut_a.u_rf.regs[1] !== 32'd5) begin bad++; $display("FAIL addiu_r1 got=%h want=00000005", dut_a.u_rf.regs[1]); end
        total++; if (ret_a - r0 != 1) begin bad++; $display("FAIL addiu_retired got=%0d want=1", ret_a - r0); end
        total++; if (imemaddr_a !== 32'h104) begin bad++; $display("FAIL next_fetch got=%h want=00000104", imemaddr_a); end
    endtask

    task automatic test_alu_ops();
        int c, mc, r0;
        logic [31:0] ma, ms;
        logic hd;
        r0 = ret_a;
        exec_instr(32'h3C038000, 2, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (c != 6) begin bad++; $display("FAIL istall_latency got=%0d want=6", c); end
        total++; if (dut_a.u_rf.regs[3] !== 32'h80000000) begin bad++; $display("FAIL lui got=%h want=80000000", dut_a.u_rf.regs[3]); end
        exec_instr(32'h3463FFFF, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (dut_a.u_rf.regs[3] !== 32'h8000FFFF) begin bad++; $display("FAIL ori got=%h want=8000ffff", dut_a.u_rf.regs[3]); end
        exec_instr(32'h00032100, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (dut_a.u_rf.regs[4] !== 32'h000FFFF0) begin bad++; $display("FAIL sll got=%h want=000ffff0", dut_a.u_rf.regs[4]); end
        exec_instr(32'h0060282A, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (dut_a.u_rf.regs[5] !== 32'd1) begin bad++; $display("FAIL slt got=%h want=00000001", dut_a.u_rf.regs[5]); end
        exec_instr(32'h00033023, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (dut_a.u_rf.regs[6] !== 32'h7FFF0001) begin bad++; $display("FAIL subu got=%h want=7fff0001", dut_a.u_rf.regs[6]); end
        exec_instr(32'h2407FFFF, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (dut_a.u_rf.regs[7] !== 32'hFFFFFFFF) begin bad++; $display("FAIL addiu_sext got=%h want=ffffffff", dut_a.u_rf.regs[7]); end
        exec_instr(32'h30E88001, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (dut_a.u_rf.regs[8] !== 32'h00008001) begin bad++; $display("FAIL andi_zext got=%h want=00008001", dut_a.u_rf.regs[8]); end
        total++; if (ret_a - r0 != 7) begin bad++; $display("FAIL alu_retired got=%0d want=7", ret_a - r0); end
    endtask

    task automatic test_load_store();
        int c, mc, r0;
        logic [31:0] ma, ms;
        logic hd;
        exec_instr(32'h24010200, 0, 0, 32'd0, c, mc, ma, ms, hd);
        exec_instr(32'h8C220004, 0, 3, 32'hDEADBEEF, c, mc, ma, ms, hd);
        total++; if (c != 8) begin bad++; $display("FAIL lw_latency got=%0d want=8", c); end
        total++; if (mc != 4 || ma !== 32'h204 || !hd) begin bad++; $display("FAIL lw_addr_hold got=%0d/%h/%b want=4/00000204/1", mc, ma, hd); end
        total++; if (dut_a.u_rf.regs[2] !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h want=deadbeef", dut_a.u_rf.regs[2]); end
        total++; if (fault_a !== 1'b0 || dmemREN_a !== 1'b0) begin bad++; $display("FAIL lw_edge_nofault got=%b%b want=00", fault_a, dmemREN_a); end
        r0 = ret_a;
        exec_instr(32'hAC220008, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (c != 4) begin bad++; $display("FAIL sw_latency got=%0d want=4", c); end
        total++; if (ma !== 32'h208 || ms !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_req got=%h/%h want=00000208/deadbeef", ma, ms); end
        total++; if (ret_a - r0 != 1 || dmemWEN_a !== 1'b0) begin bad++; $display("FAIL sw_retire got=%0d/%b want=1/0", ret_a - r0, dmemWEN_a); end
    endtask

    task automatic test_branches();
        int c, mc;
        logic [31:0] ma, ms;
        logic hd;
        exec_instr(32'h08000010, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (c != 3 || imemaddr_a !== 32'h40) begin bad++; $display("FAIL j got=%0d/%h want=3/00000040", c, imemaddr_a); end
        exec_instr(32'h1000FFFF, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (c != 3 || imemaddr_a !== 32'h40) begin bad++; $display("FAIL beq_taken got=%0d/%h want=3/00000040", c, imemaddr_a); end
        exec_instr(32'h1400FFFF, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (c != 3 || imemaddr_a !== 32'h44) begin bad++; $display("FAIL bne_not_taken got=%0d/%h want=3/00000044", c, imemaddr_a); end
    endtask

    task automatic test_jal();
        int c, mc;
        logic [31:0] ma, ms;
        logic hd;
        exec_instr(32'h0800000F, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (imemaddr_a !== 32'h3C) begin bad++; $display("FAIL j_3c got=%h want=0000003c", imemaddr_a); end
        exec_instr(32'h0C000010, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (c != 4 || imemaddr_a !== 32'h40) begin bad++; $display("FAIL jal got=%0d/%h want=4/00000040", c, imemaddr_a); end
        total++; if (dut_a.u_rf.regs[31] !== 32'h40) begin bad++; $display("FAIL jal_link got=%h want=00000040", dut_a.u_rf.regs[31]); end
    endtask

    task automatic test_overflow();
        int c, mc, r0a, r0b;
        logic [31:0] ma, ms;
        logic hd;
        exec_instr(32'h3C017FFF, 0, 0, 32'd0, c, mc, ma, ms, hd);
        exec_instr(32'h3421FFFF, 0, 0, 32'd0, c, mc, ma, ms, hd);
        r0a = ret_a; r0b = ret_b;
        exec_instr(32'h20210001, 0, 0, 32'd0, c, mc, ma, ms, hd);
        step();
        total++; if (halt_a !== 1'b1 || c != 3) begin bad++; $display("FAIL ovf_halt got=%b/%0d want=1/3", halt_a, c); end
        total++; if (dut_a.u_rf.regs[1] !== 32'h7FFFFFFF) begin bad++; $display("FAIL ovf_nowrite got=%h want=7fffffff", dut_a.u_rf.regs[1]); end
        total++; if (ret_a != r0a) begin bad++; $display("FAIL ovf_noretire got=%0d want=0", ret_a - r0a); end
        total++; if (dut_b.u_rf.regs[1] !== 32'h80000000) begin bad++; $display("FAIL ovf_wrap got=%h want=80000000", dut_b.u_rf.regs[1]); end
        total++; if (halt_b !== 1'b0 || fault_b !== 1'b0 || ret_b - r0b != 1) begin bad++; $display("FAIL ovf_b_state got=%b%b/%0d want=00/1", halt_b, fault_b, ret_b - r0b); end
        total++; if (imemREN_b !== 1'b1 || imemaddr_b !== 32'h4C) begin bad++; $display("FAIL ovf_b_fetch got=%b/%h want=1/0000004c", imemREN_b, imemaddr_b); end
    endtask

    task automatic test_halt();
        int c, mc, r0;
        logic [31:0] ma, ms;
        logic hd;
        do_reset();
        r0 = ret_a;
        exec_instr(32'hFFFFFFFF, 0, 0, 32'd0, c, mc, ma, ms, hd);
        total++; if (halt_a !== 1'b1 || c != 3 || ret_a != r0) begin bad++; $display("FAIL halt_op got=%b/%0d/%0d want=1/3/0", halt_a, c, ret_a - r0); end
        for (int k = 0; k < 6; k++) begin
            ihit = k[0];
            imemload = 32'h24010005;
            step();
            total++; if (halt_a !== 1'b1 || imemREN_a !== 1'b0) begin bad++; $display("FAIL halt_sticky_%0d got=%b%b want=10", k, halt_a, imemREN_a); end
        end
        ihit = 1'b0;
    endtask

    task automatic test_timeout();
        int c, mc;
        logic [31:0] ma, ms;
        logic hd;
        do_reset();
        exec_instr(32'hAC220008, 0, 1000, 32'd0, c, mc, ma, ms, hd);
        total++; if (c != 7 || mc != 4) begin bad++; $display("FAIL timeout_cycles got=%0d/%0d want=7/4", c, mc); end
        total++; if (ma !== 32'h80000007 || ms !== 32'hDEADBEEF || !hd) begin bad++; $display("FAIL timeout_req got=%h/%h/%b want=80000007/deadbeef/1", ma, ms, hd); end
        total++; if (fault_a !== 1'b1 || halt_a !== 1'b1 || dmemWEN_a !== 1'b0) begin bad++; $display("FAIL timeout_fault got=%b%b%b want=110", fault_a, halt_a, dmemWEN_a); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        total++; if (fault_a !== 1'b0 || halt_a !== 1'b0) begin bad++; $display("FAIL fault_cleared got=%b%b want=00", fault_a, halt_a); end
        imemload = 32'hAC220008; ihit = 1'b1;
        step();
        ihit = 1'b0; imemload = 32'd0;
        step();
        step();
        step();
        total++; if (dmemWEN_a !== 1'b1) begin bad++; $display("FAIL mid_mem_wen got=%b want=1", dmemWEN_a); end
        nRST = 1'b0;
        #1;
        total++; if ({dmemWEN_a, dmemREN_a, dmemWEN_b, dmemREN_b, imemREN_a} !== 5'b0) begin bad++; $display("FAIL mid_rst_req got=%b want=00000", {dmemWEN_a, dmemREN_a, dmemWEN_b, dmemREN_b, imemREN_a}); end
        total++; if ({dmemaddr_a, dmemaddr_b, dmemstore_b} !== 96'd0) begin bad++; $display("FAIL mid_rst_bus got=%h want=0", {dmemaddr_a, dmemaddr_b, dmemstore_b}); end
        total++; if (imemaddr_a !== 32'h100) begin bad++; $display("FAIL mid_rst_pc got=%h want=00000100", imemaddr_a); end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        total++; if (imemREN_a !== 1'b1 || imemaddr_a !== 32'h100) begin bad++; $display("FAIL refetch got=%b/%h want=1/00000100", imemREN_a, imemaddr_a); end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_alu_ops();
        test_load_store();
        test_branches();
        test_jal();
        test_overflow();
        test_halt();
        test_timeout();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
